// File: rtl/vz16_pkg.sv
// Shared types and constants for the VZ16 fetch front end.
package vz16_pkg;

  localparam logic [15:0] VZ16_RESET_PC = 16'h0000;

  // Instruction word layout: opcode [3:0], Rn [7:4], R1 [11:8], R2 [15:12].
  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH
  } fetch_state_e;

endpackage

// File: rtl/vz16_sync_fifo.sv
// Small synchronous in-order queue with flush; DEPTH must be a power of 2.
module vz16_sync_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  // Accepted push/pop; a push into a full queue is only taken alongside a pop.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
  end

  // Pointer and occupancy state; flush wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; contents are don't-care while unoccupied, so no reset.
  always_ff @(posedge clk) begin
    if (!flush && do_push) mem_q[wptr_q] <= wdata;
  end

  // Head and status outputs.
  always_comb begin
    rdata = mem_q[rptr_q];
    count = count_q;
    empty = (count_q == '0);
    full  = (count_q == CW'(DEPTH));
  end

endmodule

// File: rtl/vz16_fetch_unit.sv
// VZ16 instruction fetch: sequential address generation, credit-limited
// request issue, in-order response queue and redirect flush.
module vz16_fetch_unit
  import vz16_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = VZ16_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] dec_inst,
  output logic [15:0] dec_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q;
  logic [15:0]   fetch_pc_q;
  logic [15:0]   resp_pc_q;    // address of the next response that will be kept
  logic [CW-1:0] outstanding_q;
  logic [CW-1:0] drop_q;       // stale responses still to be discarded

  logic [CW-1:0] count;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  push_entry, head_entry;

  logic [CW:0]   credit_used;
  logic          grant, dropping, rsp_live, push, pop;
  logic [CW-1:0] drop_next, redir_drop;

  // Handshake decode and credit check.
  always_comb begin
    credit_used = {1'b0, count} + {1'b0, outstanding_q};
    imem_req    = (state_q == FETCH) && !redirect_valid && (credit_used < (CW + 1)'(DEPTH));
    grant       = imem_req && imem_gnt;
    dropping    = (drop_q != '0);
    rsp_live    = imem_rvalid && !dropping;
    push        = rsp_live && !redirect_valid;
    dec_valid   = !fifo_empty && !redirect_valid;
    pop         = dec_valid && dec_ready;
    push_entry  = '{inst: imem_rdata, pc: resp_pc_q};
    drop_next   = drop_q;
    if (imem_rvalid && dropping) drop_next = drop_q - 1'b1;
    // Outside FLUSH drop_q is 0 and inside it outstanding_q is 0, so this
    // sum never exceeds DEPTH; a response arriving now is itself dropped.
    redir_drop  = drop_q + outstanding_q - {{(CW - 1){1'b0}}, imem_rvalid};
  end

  // Fetch FSM with PC, shadow response PC and in-flight/drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else if (redirect_valid) begin
      fetch_pc_q    <= redirect_pc;
      resp_pc_q     <= redirect_pc;
      outstanding_q <= '0;
      drop_q        <= redir_drop;
      state_q       <= (redir_drop != '0) ? FLUSH : FETCH;
    end else begin
      if (grant) fetch_pc_q <= fetch_pc_q + 1'b1;
      if (push)  resp_pc_q  <= resp_pc_q + 1'b1;
      case ({grant, rsp_live})
        2'b10:   outstanding_q <= outstanding_q + 1'b1;
        2'b01:   outstanding_q <= outstanding_q - 1'b1;
        default: outstanding_q <= outstanding_q;
      endcase
      drop_q <= drop_next;
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   state_q <= FETCH;
        FLUSH:   state_q <= (drop_next == '0) ? FETCH : FLUSH;
        default: state_q <= IDLE;
      endcase
    end
  end

  vz16_sync_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Decoder-facing outputs, forced to zero while the queue is empty.
  always_comb begin
    imem_addr = fetch_pc_q;
    dec_inst  = fifo_empty ? 16'h0000 : head_entry.inst;
    dec_pc    = fifo_empty ? 16'h0000 : head_entry.pc;
  end

  // Memory must never return more responses than were granted.
  rvalid_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> ((outstanding_q != '0) || (drop_q != '0)));

  // The credit rule makes a push into a full queue without a pop impossible.
  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (!fifo_full || pop));

endmodule
